// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
// Shared definitions for the sequential restoring divider: the FSM state
// encoding and the width helper used to size the iteration counter.
// No ports (package).

package seq_divider_pkg;

  // Code 2'd3 is unused; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ceil(log2(value)), never less than 1 so a counter always has a bit.
  function automatic int clog2_min1(input int value);
    int width;
    int v;
    width = 0;
    v     = value - 1;
    while (v > 0) begin
      width++;
      v = v >> 1;
    end
    if (width < 1) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/seq_divider_subtractor_cell.sv
// subtractor_cell
// Combinational (N_BITS+1)-bit subtractor built as a ripple of
// full-subtractor bit cells, the same construction the multiplier uses for
// its adder cells.
// Ports:
//   a      in  N_BITS+1  minuend
//   b      in  N_BITS+1  subtrahend
//   diff   out N_BITS+1  a - b (modulo 2^(N_BITS+1))
//   borrow out 1         set when b > a

module subtractor_cell #(
  parameter int N_BITS = 4
) (
  input  logic [N_BITS:0] a,
  input  logic [N_BITS:0] b,
  output logic [N_BITS:0] diff,
  output logic            borrow
);

  logic [N_BITS+1:0] chain;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i <= N_BITS; i++) begin : g_cell
    // Full subtractor: borrow out when this bit needs to take from above.
    assign diff[i]      = a[i] ^ b[i] ^ chain[i];
    assign chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
  end

  assign borrow = chain[N_BITS+1];

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Sequential unsigned restoring divider: one quotient bit per clock,
// results after N_BITS iterations, start/done handshake.
// Ports:
//   clk          in  1       rising-edge clock
//   rst          in  1       asynchronous active-high reset
//   start        in  1       request, sampled only in IDLE
//   dividend     in  N_BITS  numerator, captured on accepted start
//   divisor      in  N_BITS  denominator, captured on accepted start
//   busy         out 1       high while iterating
//   done         out 1       one-cycle pulse, results valid
//   quotient     out N_BITS  result, held until next accepted start
//   remainder    out N_BITS  result, held until next accepted start
//   div_by_zero  out 1       set with done when divisor was 0

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] dividend,
  input  logic [N_BITS-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] quotient,
  output logic [N_BITS-1:0] remainder,
  output logic              div_by_zero
);

  localparam int               CNT_W    = clog2_min1(N_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  state_t state, state_next;

  logic [N_BITS-1:0] dvd_reg;
  logic [N_BITS-1:0] dvs_reg;
  logic [N_BITS:0]   rem_reg;
  logic [CNT_W-1:0]  cnt;

  logic [N_BITS:0]   step_t;
  logic [N_BITS:0]   step_diff;
  logic              step_borrow;
  logic              qbit;
  logic [N_BITS:0]   rem_step;
  logic [N_BITS-1:0] dvd_step;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor.
  assign step_t = {rem_reg[N_BITS-1:0], dvd_reg[N_BITS-1]};

  subtractor_cell #(.N_BITS(N_BITS)) u_sub (
    .a      (step_t),
    .b      ({1'b0, dvs_reg}),
    .diff   (step_diff),
    .borrow (step_borrow)
  );

  // rem_reg stays below the divisor, so its top bit is always 0. If it were
  // ever set, the shifted value would exceed the divisor and the subtract
  // must succeed, which is what OR-ing it in expresses.
  assign qbit     = rem_reg[N_BITS] | ~step_borrow;
  assign rem_step = qbit ? step_diff : step_t;
  assign dvd_step = {dvd_reg[N_BITS-2:0], qbit};

  // State register; busy and done are registered from the next state so
  // they come straight out of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_RUN);
      done  <= (state_next == ST_DONE);
    end
  end

  // Next-state logic. A zero divisor skips RUN entirely.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN:  state_next = (cnt == CNT_LAST) ? ST_DONE : ST_RUN;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dvd_reg     <= dividend;
              dvs_reg     <= divisor;
              rem_reg     <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          rem_reg <= rem_step;
          dvd_reg <= dvd_step;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            quotient  <= dvd_step;
            remainder <= rem_step[N_BITS-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Directed self-checking bench for seq_divider with N_BITS = 4.

module tb_seq_divider;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks;
  int fails;

  seq_divider #(.N_BITS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one divide (called at a negedge) and samples each following
  // negedge. done_edge is the index of the edge after which done was first
  // seen (edge 0 is the accepting edge), or -1 on timeout.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int done_edge, output int busy_cycles,
                        output bit overlap);
    done_edge   = -1;
    busy_cycles = 0;
    overlap     = 1'b0;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0d, expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %0d, expected 0", done); end
    checks++; if (div_by_zero !== 1'b0) begin fails++; $display("[TB] FAIL reset_dbz: got %0d, expected 0", div_by_zero); end
    checks++; if (quotient !== 4'd0) begin fails++; $display("[TB] FAIL reset_quotient: got %0d, expected 0", quotient); end
    checks++; if (remainder !== 4'd0) begin fails++; $display("[TB] FAIL reset_remainder: got %0d, expected 0", remainder); end
  endtask

  task automatic test_basic();
    int de, bc;
    bit ov;
    logic [N-1:0] va [4] = '{4'd13, 4'd15, 4'd5, 4'd15};
    logic [N-1:0] vb [4] = '{4'd3,  4'd1,  4'd7, 4'd15};
    logic [N-1:0] vq [4] = '{4'd4,  4'd15, 4'd0, 4'd1};
    logic [N-1:0] vr [4] = '{4'd1,  4'd0,  4'd5, 4'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], de, bc, ov);
      checks++; if (de !== 4) begin fails++; $display("[TB] FAIL basic_latency %0d/%0d: got edge %0d, expected 4", va[i], vb[i], de); end
      checks++; if (bc !== 4) begin fails++; $display("[TB] FAIL basic_busy_cycles %0d/%0d: got %0d, expected 4", va[i], vb[i], bc); end
      checks++; if (ov !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_done_overlap %0d/%0d: got 1, expected 0", va[i], vb[i]); end
      checks++; if (quotient !== vq[i]) begin fails++; $display("[TB] FAIL basic_quotient %0d/%0d: got %0d, expected %0d", va[i], vb[i], quotient, vq[i]); end
      checks++; if (remainder !== vr[i]) begin fails++; $display("[TB] FAIL basic_remainder %0d/%0d: got %0d, expected %0d", va[i], vb[i], remainder, vr[i]); end
      checks++; if (div_by_zero !== 1'b0) begin fails++; $display("[TB] FAIL basic_dbz %0d/%0d: got %0d, expected 0", va[i], vb[i], div_by_zero); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_width %0d/%0d: got %0d, expected 0", va[i], vb[i], done); end
    end
  endtask

  task automatic test_div_by_zero();
    int de, bc;
    bit ov;
    run_op(4'd9, 4'd0, de, bc, ov);
    checks++; if (de !== 0) begin fails++; $display("[TB] FAIL dbz_latency: got edge %0d, expected 0", de); end
    checks++; if (bc !== 0) begin fails++; $display("[TB] FAIL dbz_busy_cycles: got %0d, expected 0", bc); end
    checks++; if (quotient !== 4'd15) begin fails++; $display("[TB] FAIL dbz_quotient: got %0d, expected 15", quotient); end
    checks++; if (remainder !== 4'd9) begin fails++; $display("[TB] FAIL dbz_remainder: got %0d, expected 9", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin fails++; $display("[TB] FAIL dbz_flag: got %0d, expected 1", div_by_zero); end
    @(negedge clk);
    checks++; if (div_by_zero !== 1'b1) begin fails++; $display("[TB] FAIL dbz_flag_held: got %0d, expected 1", div_by_zero); end
    run_op(4'd8, 4'd2, de, bc, ov);
    checks++; if (de !== 4) begin fails++; $display("[TB] FAIL dbz_next_latency: got edge %0d, expected 4", de); end
    checks++; if (quotient !== 4'd4) begin fails++; $display("[TB] FAIL dbz_next_quotient: got %0d, expected 4", quotient); end
    checks++; if (remainder !== 4'd0) begin fails++; $display("[TB] FAIL dbz_next_remainder: got %0d, expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin fails++; $display("[TB] FAIL dbz_cleared: got %0d, expected 0", div_by_zero); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [N-1:0] q_seen, r_seen;
    pulses   = 0;
    q_seen   = '0;
    r_seen   = '0;
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        q_seen = quotient;
        r_seen = remainder;
      end
    end
    checks++; if (pulses !== 1) begin fails++; $display("[TB] FAIL ignore_done_pulses: got %0d, expected 1", pulses); end
    checks++; if (q_seen !== 4'd4) begin fails++; $display("[TB] FAIL ignore_quotient: got %0d, expected 4", q_seen); end
    checks++; if (r_seen !== 4'd1) begin fails++; $display("[TB] FAIL ignore_remainder: got %0d, expected 1", r_seen); end
  endtask

  task automatic test_reset_mid_run();
    int de, bc, stray;
    bit ov;
    stray    = 0;
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %0d, expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL midrst_done: got %0d, expected 0", done); end
    checks++; if (quotient !== 4'd0) begin fails++; $display("[TB] FAIL midrst_quotient: got %0d, expected 0", quotient); end
    checks++; if (remainder !== 4'd0) begin fails++; $display("[TB] FAIL midrst_remainder: got %0d, expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin fails++; $display("[TB] FAIL midrst_dbz: got %0d, expected 0", div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    checks++; if (stray !== 0) begin fails++; $display("[TB] FAIL midrst_stray_activity: got %0d cycles, expected 0", stray); end
    run_op(4'd12, 4'd5, de, bc, ov);
    checks++; if (de !== 4) begin fails++; $display("[TB] FAIL midrst_next_latency: got edge %0d, expected 4", de); end
    checks++; if (quotient !== 4'd2) begin fails++; $display("[TB] FAIL midrst_next_quotient: got %0d, expected 2", quotient); end
    checks++; if (remainder !== 4'd2) begin fails++; $display("[TB] FAIL midrst_next_remainder: got %0d, expected 2", remainder); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int done_at [3];
    int n_done, hold_err, overlap_err;
    n_done      = 0;
    hold_err    = 0;
    overlap_err = 0;
    for (int k = 0; k < 3; k++) done_at[k] = -1;
    // 14/4 = 3 r 2 for the first divide, then 11/2 = 5 r 1.
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    for (int e = 0; e < 18; e++) begin
      @(negedge clk);
      if (done) begin
        if (n_done < 3) done_at[n_done] = e;
        n_done++;
      end
      if (busy && done) overlap_err++;
      if (e >= 4 && e <= 9 && (quotient !== 4'd3 || remainder !== 4'd2)) hold_err++;
      if (e >= 10 && (quotient !== 4'd5 || remainder !== 4'd1)) hold_err++;
      if (e == 5) begin
        dividend = 4'd11;
        divisor  = 4'd2;
      end
      if (e == 17) start = 1'b0;
    end
    checks++; if (n_done !== 3) begin fails++; $display("[TB] FAIL b2b_done_count: got %0d, expected 3", n_done); end
    checks++; if (done_at[0] !== 4) begin fails++; $display("[TB] FAIL b2b_first_done: got edge %0d, expected 4", done_at[0]); end
    checks++; if (done_at[1] !== 10) begin fails++; $display("[TB] FAIL b2b_second_done: got edge %0d, expected 10", done_at[1]); end
    checks++; if (done_at[2] !== 16) begin fails++; $display("[TB] FAIL b2b_third_done: got edge %0d, expected 16", done_at[2]); end
    checks++; if (hold_err !== 0) begin fails++; $display("[TB] FAIL b2b_results_hold: got %0d bad cycles, expected 0", hold_err); end
    checks++; if (overlap_err !== 0) begin fails++; $display("[TB] FAIL b2b_busy_done_overlap: got %0d, expected 0", overlap_err); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
